iddr_word_aligner: RTL and testbench

- Sits directly downstream of the IDDR input primitive and consumes its Q1/Q2 bit pair on every enabled clock.
- Assembles the 2-bit-per-cycle stream into WIDTH-bit words.
- During training, hunts for a known pattern by bit-slipping the word boundary, then declares lock.
- Delivers aligned words with a valid strobe to the link/protocol logic.

---
 rtl/iddr_word_aligner.sv | 173 +++++++++++++++++
 tb/tb_iddr_word_aligner.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iddr_word_aligner.sv
// Word aligner for an IDDR Q1/Q2 bit-pair stream: assembles WIDTH-bit words,
// bit-slips the boundary against a training pattern, and reports lock.
module iddr_word_aligner #(
  parameter int                 WIDTH         = 8,
  parameter logic [WIDTH-1:0]   TRAIN_PATTERN = 8'hA7,
  parameter int                 LOCK_COUNT    = 4
) (
  input  logic                       C,
  input  logic                       R,
  input  logic                       CE,
  input  logic                       Q1,
  input  logic                       Q2,
  input  logic                       TRAIN,
  input  logic                       RELOCK,
  output logic [WIDTH-1:0]           DATA,
  output logic                       VALID,
  output logic                       LOCKED,
  output logic [$clog2(WIDTH)-1:0]   OFFSET,
  output logic                       ALIGN_ERR
);

  localparam int OW = $clog2(WIDTH);
  localparam int PW = $clog2(WIDTH / 2);
  localparam int HW = 2 * WIDTH;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_SETTLE,
    ST_CHECK,
    ST_LOCK
  } state_t;

  state_t           state_q, state_d;
  logic [HW-1:0]    hist_q, hist_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic [1:0]       warm_q, warm_d;
  logic [3:0]       match_q, match_d;
  logic [OW-1:0]    slip_q, slip_d;
  logic [OW-1:0]    offset_q, offset_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;

  logic             boundary;
  logic             evaluate;
  logic             do_slip;
  logic             is_match;
  logic [OW:0]      base;
  logic [WIDTH-1:0] word;

  always_comb begin
    state_d  = state_q;
    hist_d   = hist_q;
    phase_d  = phase_q;
    warm_d   = warm_q;
    match_d  = match_q;
    slip_d   = slip_q;
    offset_d = offset_q;
    err_d    = err_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    boundary = 1'b0;
    evaluate = 1'b0;
    do_slip  = 1'b0;

    if (CE) begin
      hist_d = {hist_q[HW-3:0], Q1, Q2};
      if (phase_q == PW'(WIDTH / 2 - 1)) begin
        phase_d  = '0;
        boundary = 1'b1;
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end

    // Word is cut from the post-shift history so the last pair is included.
    base     = {1'b0, offset_q};
    word     = hist_d[base +: WIDTH];
    is_match = (word == TRAIN_PATTERN);

    if (boundary) begin
      if (warm_q != 2'd2) begin
        warm_d = warm_q + 2'd1;
      end else begin
        data_d   = word;
        valid_d  = 1'b1;
        evaluate = TRAIN && !RELOCK;
      end
    end

    if (evaluate) begin
      unique case (state_q)
        ST_HUNT: begin
          if (is_match) begin
            match_d = 4'd1;
            state_d = (LOCK_COUNT == 1) ? ST_LOCK : ST_CHECK;
          end else begin
            do_slip = 1'b1;
          end
        end
        ST_SETTLE: state_d = ST_HUNT;
        ST_CHECK: begin
          if (is_match) begin
            match_d = match_q + 4'd1;
            if (match_q + 4'd1 == 4'(LOCK_COUNT)) state_d = ST_LOCK;
          end else begin
            do_slip = 1'b1;
          end
        end
        ST_LOCK: ;
        default: ;
      endcase
    end

    if (do_slip) begin
      state_d  = ST_SETTLE;
      match_d  = '0;
      offset_d = (offset_q == OW'(WIDTH - 1)) ? '0 : offset_q + 1'b1;
      if (slip_q == OW'(WIDTH - 1)) begin
        slip_d = '0;
        err_d  = 1'b1;
      end else begin
        slip_d = slip_q + 1'b1;
      end
    end

    // Relock wins over any evaluation; the offset is deliberately retained.
    if (RELOCK) begin
      state_d = ST_HUNT;
      match_d = '0;
      slip_d  = '0;
      err_d   = 1'b0;
    end

    locked_d = (state_d == ST_LOCK);
  end

  always_ff @(posedge C) begin
    if (R) begin
      state_q  <= ST_HUNT;
      hist_q   <= '0;
      phase_q  <= '0;
      warm_q   <= '0;
      match_q  <= '0;
      slip_q   <= '0;
      offset_q <= '0;
      err_q    <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hist_q   <= hist_d;
      phase_q  <= phase_d;
      warm_q   <= warm_d;
      match_q  <= match_d;
      slip_q   <= slip_d;
      offset_q <= offset_d;
      err_q    <= err_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
    end
  end

  assign DATA      = data_q;
  assign VALID     = valid_q;
  assign LOCKED    = locked_q;
  assign OFFSET    = offset_q;
  assign ALIGN_ERR = err_q;

endmodule

// File: tb/tb_iddr_word_aligner.sv
// Randomized self-checking bench for iddr_word_aligner against a bit-stream
// reference model.
module tb_iddr_word_aligner;

  localparam int         WIDTH      = 8;
  localparam logic [7:0] PAT        = 8'hA7;
  localparam int         LOCK_COUNT = 4;
  localparam int         HALF       = WIDTH / 2;

  logic       C = 1'b0;
  logic       R = 1'b1, CE = 1'b0, Q1 = 1'b0, Q2 = 1'b0, TRAIN = 1'b0, RELOCK = 1'b0;
  logic [7:0] DATA;
  logic       VALID, LOCKED, ALIGN_ERR;
  logic [2:0] OFFSET;

  int n_vec = 0;
  int n_bad = 0;

  iddr_word_aligner #(
    .WIDTH        (WIDTH),
    .TRAIN_PATTERN(PAT),
    .LOCK_COUNT   (LOCK_COUNT)
  ) dut (
    .C        (C),
    .R        (R),
    .CE       (CE),
    .Q1       (Q1),
    .Q2       (Q2),
    .TRAIN    (TRAIN),
    .RELOCK   (RELOCK),
    .DATA     (DATA),
    .VALID    (VALID),
    .LOCKED   (LOCKED),
    .OFFSET   (OFFSET),
    .ALIGN_ERR(ALIGN_ERR)
  );

  always #5 C = ~C;

  // Reference model: the received bit stream plus alignment bookkeeping.
  bit         bits[$];
  int         m_pairs, m_bounds, m_matches, m_slips, m_off;
  bit         m_locked, m_skip, m_err, m_valid;
  logic [7:0] m_data;
  int         sp;

  function automatic logic [7:0] m_word();
    logic [7:0] w;
    for (int k = 0; k < WIDTH; k++) begin
      int idx;
      idx = bits.size() - 1 - (m_off + k);
      w[k] = (idx >= 0) ? bits[idx] : 1'b0;
    end
    return w;
  endfunction

  function automatic logic [13:0] m_out();
    logic [2:0] o;
    o = 3'(m_off);
    return {m_locked, m_err, m_valid, o, m_data};
  endfunction

  function automatic bit pbit(int s, int skew);
    logic [7:0] p;
    p = PAT;
    return p[7 - ((s + skew) % WIDTH)];
  endfunction

  task automatic model_step(bit r, bit ce, bit q1, bit q2, bit train, bit relock);
    logic [7:0] w;
    if (r) begin
      bits.delete();
      m_pairs = 0; m_bounds = 0; m_matches = 0; m_slips = 0; m_off = 0;
      m_locked = 0; m_skip = 0; m_err = 0; m_valid = 0; m_data = '0;
      return;
    end
    m_valid = 0;
    if (ce) begin
      bits.push_back(q1);
      bits.push_back(q2);
      while (bits.size() > 64) void'(bits.pop_front());
      m_pairs = (m_pairs + 1) % HALF;
      if (m_pairs == 0) begin
        w = m_word();
        if (m_bounds < 2) m_bounds++;
        else begin
          m_data = w; m_valid = 1;
          if (train && !relock && !m_locked) begin
            if (m_skip) m_skip = 0;
            else if (w == PAT) begin
              m_matches++;
              if (m_matches >= LOCK_COUNT) m_locked = 1;
            end else begin
              m_matches = 0; m_skip = 1;
              m_off = (m_off + 1) % WIDTH;
              m_slips++;
              if (m_slips == WIDTH) begin m_err = 1; m_slips = 0; end
            end
          end
        end
      end
    end
    if (relock) begin
      m_locked = 0; m_skip = 0; m_matches = 0; m_slips = 0; m_err = 0;
    end
  endtask

  task automatic drive_cycle(bit r, bit ce, bit q1, bit q2, bit train, bit relock);
    R = r; CE = ce; Q1 = q1; Q2 = q2; TRAIN = train; RELOCK = relock;
    @(posedge C);
    model_step(r, ce, q1, q2, train, relock);
    #1;
  endtask

  task automatic test_reset();
    int first_valid;
    for (int i = 0; i < 2; i++) drive_cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive_cycle(0, 1, 1'($urandom), 1'($urandom), 1, 0);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1, 1, 1'($urandom), 1'($urandom), 1, 0);
      n_vec++;
      if ({LOCKED, ALIGN_ERR, VALID, OFFSET, DATA} !== 14'd0) begin
        n_bad++;
        $display("FAIL reset_zero cyc=%0d got=%h want=%h", i, {LOCKED, ALIGN_ERR, VALID, OFFSET, DATA}, 14'd0);
      end
    end
    sp = 0;
    first_valid = -1;
    for (int i = 1; i <= 14; i++) begin
      drive_cycle(0, 1, 1'($urandom), 1'($urandom), 0, 0);
      n_vec++;
      if ({LOCKED, ALIGN_ERR, VALID, OFFSET, DATA} !== m_out()) begin
        n_bad++;
        $display("FAIL reset_warmup cyc=%0d got=%h want=%h", i, {LOCKED, ALIGN_ERR, VALID, OFFSET, DATA}, m_out());
      end
      if (VALID === 1'b1 && first_valid < 0) first_valid = i;
    end
    n_vec++;
    if (first_valid != 3 * HALF) begin
      n_bad++;
      $display("FAIL reset_first_valid got=%0d want=%0d", first_valid, 3 * HALF);
    end
  endtask

  task automatic test_aligned();
    int lock_at;
    drive_cycle(1, 0, 0, 0, 0, 0);
    sp = 0; lock_at = -1;
    for (int i = 1; i <= 40; i++) begin
      drive_cycle(0, 1, pbit(sp, 0), pbit(sp + 1, 0), 1, 0);
      sp += 2;
      n_vec++;
      if ({LOCKED, ALIGN_ERR, VALID, OFFSET, DATA} !== m_out()) begin
        n_bad++;
        $display("FAIL aligned cyc=%0d got=%h want=%h", i, {LOCKED, ALIGN_ERR, VALID, OFFSET, DATA}, m_out());
      end
      if (LOCKED === 1'b1 && lock_at < 0) lock_at = i;
    end
    n_vec++;
    if (lock_at != (2 + LOCK_COUNT) * HALF || OFFSET !== 3'd0) begin
      n_bad++;
      $display("FAIL aligned_lock lock_cyc=%0d off=%0d want lock_cyc=%0d off=0", lock_at, OFFSET, (2 + LOCK_COUNT) * HALF);
    end
  endtask

  task automatic test_skew();
    int lock_at;
    drive_cycle(1, 0, 0, 0, 0, 0);
    sp = 0; lock_at = -1;
    for (int i = 1; i <= 60; i++) begin
      drive_cycle(0, 1, pbit(sp, 3), pbit(sp + 1, 3), 1, 0);
      sp += 2;
      n_vec++;
      if ({LOCKED, ALIGN_ERR, VALID, OFFSET, DATA} !== m_out()) begin
        n_bad++;
        $display("FAIL skew cyc=%0d got=%h want=%h", i, {LOCKED, ALIGN_ERR, VALID, OFFSET, DATA}, m_out());
      end
      if (LOCKED === 1'b1 && lock_at < 0) lock_at = i;
    end
    n_vec++;
    if (lock_at != 12 * HALF || OFFSET !== 3'd3 || ALIGN_ERR !== 1'b0) begin
      n_bad++;
      $display("FAIL skew_lock lock_cyc=%0d off=%0d err=%b want lock_cyc=%0d off=3 err=0", lock_at, OFFSET, ALIGN_ERR, 12 * HALF);
    end
  endtask

  task automatic test_ce_gating();
    logic [7:0] prev;
    int         nvalid;
    nvalid = 0;
    for (int i = 0; i < 32; i++) begin
      bit ce;
      ce = (i % 2 == 0);
      prev = DATA;
      if (ce) begin
        drive_cycle(0, 1, pbit(sp, 3), pbit(sp + 1, 3), 1, 0);
        sp += 2;
      end else begin
        drive_cycle(0, 0, 1'($urandom), 1'($urandom), 1, 0);
      end
      n_vec++;
      if ({LOCKED, ALIGN_ERR, VALID, OFFSET, DATA} !== m_out() || (!ce && (DATA !== prev || VALID !== 1'b0))) begin
        n_bad++;
        $display("FAIL ce_gating cyc=%0d ce=%b got=%h want=%h prev_data=%h", i, ce, {LOCKED, ALIGN_ERR, VALID, OFFSET, DATA}, m_out(), prev);
      end
      if (VALID === 1'b1) nvalid++;
    end
    n_vec++;
    if (nvalid != 16 / HALF || LOCKED !== 1'b1) begin
      n_bad++;
      $display("FAIL ce_gating_count valids=%0d locked=%b want valids=%0d locked=1", nvalid, LOCKED, 16 / HALF);
    end
  endtask

  task automatic test_relock();
    int  lock_at;
    bit  fired;
    fired = 0; lock_at = -1;
    for (int i = 0; i < 8 && !fired; i++) begin
      bit rl;
      rl = (m_pairs == HALF - 1);
      drive_cycle(0, 1, pbit(sp, 3), pbit(sp + 1, 3), 1, rl);
      sp += 2;
      if (rl) begin
        fired = 1;
        n_vec++;
        if (VALID !== 1'b1 || LOCKED !== 1'b0 || OFFSET !== 3'd3 || DATA !== PAT) begin
          n_bad++;
          $display("FAIL relock_pulse valid=%b locked=%b off=%0d data=%h want 1 0 3 %h", VALID, LOCKED, OFFSET, DATA, PAT);
        end
      end
    end
    for (int i = 1; i <= 20; i++) begin
      drive_cycle(0, 1, pbit(sp, 3), pbit(sp + 1, 3), 1, 0);
      sp += 2;
      n_vec++;
      if ({LOCKED, ALIGN_ERR, VALID, OFFSET, DATA} !== m_out() || OFFSET !== 3'd3) begin
        n_bad++;
        $display("FAIL relock cyc=%0d got=%h want=%h", i, {LOCKED, ALIGN_ERR, VALID, OFFSET, DATA}, m_out());
      end
      if (LOCKED === 1'b1 && lock_at < 0) lock_at = i;
    end
    n_vec++;
    if (!fired || lock_at != LOCK_COUNT * HALF) begin
      n_bad++;
      $display("FAIL relock_time fired=%b lock_cyc=%0d want lock_cyc=%0d", fired, lock_at, LOCK_COUNT * HALF);
    end
  endtask

  task automatic test_no_pattern();
    drive_cycle(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 100; i++) begin
      drive_cycle(0, 1, 1'($urandom), 1'($urandom), 1, 0);
      n_vec++;
      if ({LOCKED, ALIGN_ERR, VALID, OFFSET, DATA} !== m_out()) begin
        n_bad++;
        $display("FAIL no_pattern cyc=%0d got=%h want=%h", i, {LOCKED, ALIGN_ERR, VALID, OFFSET, DATA}, m_out());
      end
    end
    n_vec++;
    if (ALIGN_ERR !== 1'b1 || LOCKED !== 1'b0) begin
      n_bad++;
      $display("FAIL no_pattern_err err=%b locked=%b want err=1 locked=0", ALIGN_ERR, LOCKED);
    end
  endtask

  task automatic test_random_mix();
    int skew;
    drive_cycle(1, 0, 0, 0, 0, 0);
    sp = 0;
    skew = $urandom_range(0, WIDTH - 1);
    for (int i = 1; i <= 400; i++) begin
      bit r, ce, tr, rl, q1, q2;
      r  = ($urandom_range(0, 99) < 2);
      ce = ($urandom_range(0, 99) < 75);
      tr = ($urandom_range(0, 99) < 80);
      rl = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 70) begin
        q1 = pbit(sp, skew); q2 = pbit(sp + 1, skew);
      end else begin
        q1 = 1'($urandom); q2 = 1'($urandom);
      end
      if (ce) sp += 2;
      if (r) skew = $urandom_range(0, WIDTH - 1);
      drive_cycle(r, ce, q1, q2, tr, rl);
      n_vec++;
      if ({LOCKED, ALIGN_ERR, VALID, OFFSET, DATA} !== m_out()) begin
        n_bad++;
        $display("FAIL random cyc=%0d got=%h want=%h", i, {LOCKED, ALIGN_ERR, VALID, OFFSET, DATA}, m_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_skew();
    test_ce_gating();
    test_relock();
    test_no_pattern();
    test_random_mix();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout vectors=%0d", n_vec);
    $fatal(1, "timeout");
  end

endmodule
